pipe_mul: RTL and testbench
===========================

PIPE_MUL -- requirements
Module: pipe_mul

Interface
REQ-001 Parameter WIDTH, default 32, sets the operand and result width in bits (legal 8..64).
REQ-002 Parameter STAGES, default 2, sets the total register stages and therefore the latency in cycles (legal 2..4).
REQ-003 Port clk  input  1  is the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst_n  input  1  is the reset: synchronous, active-low.
REQ-005 Port stall  input  1  SHALL freeze every pipeline register while high.
REQ-006 Port flush  input  1  SHALL kill all in-flight operations.
REQ-007 Port in_valid  input  1  SHALL qualify opA, opB and op.
REQ-008 Port op  input  2  SHALL select the operation: 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU.
REQ-009 Ports opA and opB  input  WIDTH  SHALL carry the multiplicand and the multiplier.
REQ-010 Port out_valid  output  1  SHALL be high when result holds a completed operation.
REQ-011 Port result  output  WIDTH  SHALL be driven directly from the final-stage register, with no combinational path from any input.

Function
REQ-012 Stage 1 SHALL register opA, opB, op and in_valid.
REQ-013 The product SHALL be computed from the stage-1 registers and passed through STAGES-2 intermediate 2*WIDTH-bit registers into the final result register.
REQ-014 With stall low, result and out_valid SHALL reflect an input sampled on edge N at edge N+STAGES.
REQ-015 Data registers SHALL load on every non-stalled edge regardless of valid; valid bits travel alongside the data and qualify it.
REQ-016 Arithmetic: extend each operand to WIDTH+1 bits (sign-extend for signed, zero-extend for unsigned), then form the 2*WIDTH-bit product.
REQ-017 Operand signedness: opA is signed for MULH and MULHSU; opB is signed for MULH only.
REQ-018 Result selection: MUL returns product bits [WIDTH-1:0]; MULH, MULHSU and MULHU return bits [2*WIDTH-1:WIDTH].
REQ-019 While stall is high, all stage data registers, valid bits, result and out_valid SHALL hold their values.
REQ-020 When flush is high on an edge, all valid bits including out_valid SHALL clear to 0; the data registers follow the stall rule.
REQ-021 flush SHALL take priority over stall, so valid bits clear even while stalled.
REQ-022 An input presented with in_valid high in the same cycle as flush SHALL be discarded.
REQ-023 Back-to-back issue SHALL sustain one operation per cycle, with no bubbles and no reordering.
REQ-024 If stall is released while flush is low, the pipeline SHALL resume exactly where it froze, with no loss or duplication.

Reset
REQ-025 On an edge with rst_n low, all stage registers, all valid bits, result and out_valid SHALL become 0.
REQ-026 Reset SHALL take priority over both stall and flush.
REQ-027 Any operation in flight when reset asserts SHALL be lost and SHALL never produce out_valid.
REQ-028 The first input accepted after rst_n rises SHALL produce out_valid exactly STAGES edges later.

Configuration
REQ-029 Macro PIPE_MUL_HIGH_EN SHALL be the only compile-time option.
REQ-030 With PIPE_MUL_HIGH_EN defined, all four op encodings SHALL behave as in REQ-016 to REQ-018.
REQ-031 Without PIPE_MUL_HIGH_EN, op SHALL be ignored and not registered, result SHALL always be the low half, and the upper-half product logic SHALL be absent.

Verification
REQ-032 WIDTH=32, STAGES=2, opA=opB=0xFFFFFFFF, issue op=00, 01, 10, 11 on consecutive cycles -> result 0x00000001, 0x00000000, 0xFFFFFFFF, 0xFFFFFFFE on consecutive cycles starting 2 edges after the first issue.
REQ-033 opA=opB=0x80000000, op=01 -> result 0x40000000; same operands with op=00 -> result 0x00000000.
REQ-034 STAGES=2, issue 7*6 at edge 1, stall high across edges 2-3 -> out_valid first high after edge 4 with result 42, held during the stall.
REQ-035 Issue three ops on consecutive edges, assert flush at the edge after the second issue -> none of the three ever asserts out_valid.
REQ-036 Assert rst_n low for one edge with two ops in flight -> result=0 and out_valid=0 on that edge; a new op issued at the next edge appears STAGES edges later.
REQ-037 Build without PIPE_MUL_HIGH_EN, opA=opB=0xFFFFFFFF, op=11 -> result 0x00000001.

Source files
------------

// File: rtl/pipe_mul.sv
// pipe_mul: WIDTH x WIDTH multiplier, STAGES register stages from operand capture to result.
// Define PIPE_MUL_HIGH_EN to build MULH/MULHSU/MULHU; without it only the low half (MUL) exists.
module pipe_mul #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] opA,
    input  logic [WIDTH-1:0] opB,
    output logic             out_valid,
    output logic [WIDTH-1:0] result
);
`ifdef PIPE_MUL_HIGH_EN
    localparam int unsigned PW = 2 * WIDTH;
`else
    localparam int unsigned PW = WIDTH;
`endif

    logic [WIDTH-1:0] a1_q;
    logic [WIDTH-1:0] b1_q;
    logic             v1_q;
    logic [PW-1:0]    prod_c;
    logic [PW-1:0]    fin_prod_c;
    logic             fin_v_c;
    logic [WIDTH-1:0] result_d;

    // Stage 1: operand capture; valid is killed by flush even while stalled
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a1_q <= '0;
            b1_q <= '0;
            v1_q <= 1'b0;
        end else begin
            if (!stall) begin
                a1_q <= opA;
                b1_q <= opB;
            end
            if (flush) begin
                v1_q <= 1'b0;
            end else if (!stall) begin
                v1_q <= in_valid;
            end
        end
    end

`ifdef PIPE_MUL_HIGH_EN
    logic [1:0]                op1_q;
    logic [1:0]                fin_op_c;
    logic signed [WIDTH:0]     ext_a_c;
    logic signed [WIDTH:0]     ext_b_c;
    logic signed [2*WIDTH+1:0] full_c;
    logic                      unused_full_c;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op1_q <= 2'b00;
        end else if (!stall) begin
            op1_q <= op;
        end
    end

    // opA is signed for MULH/MULHSU, opB only for MULH
    always_comb begin
        ext_a_c = {(op1_q == 2'b01 || op1_q == 2'b10) && a1_q[WIDTH-1], a1_q};
        ext_b_c = {(op1_q == 2'b01) && b1_q[WIDTH-1], b1_q};
        full_c  = (2*WIDTH+2)'(ext_a_c) * (2*WIDTH+2)'(ext_b_c);
        prod_c  = full_c[PW-1:0];
    end

    assign unused_full_c = ^full_c[2*WIDTH+1:2*WIDTH];
`else
    logic unused_op_c;

    always_comb begin
        prod_c = a1_q * b1_q;
    end

    assign unused_op_c = ^op;
`endif

    if (STAGES > 2) begin : g_mid
        localparam int unsigned NMID = STAGES - 2;

        logic [PW-1:0]   mid_q [NMID];
        logic [NMID-1:0] midv_q;
`ifdef PIPE_MUL_HIGH_EN
        logic [1:0]      midop_q [NMID];
`endif

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                for (int unsigned i = 0; i < NMID; i++) begin
                    mid_q[i] <= '0;
`ifdef PIPE_MUL_HIGH_EN
                    midop_q[i] <= 2'b00;
`endif
                end
                midv_q <= '0;
            end else begin
                if (!stall) begin
                    mid_q[0] <= prod_c;
`ifdef PIPE_MUL_HIGH_EN
                    midop_q[0] <= op1_q;
`endif
                    for (int unsigned i = 1; i < NMID; i++) begin
                        mid_q[i] <= mid_q[i-1];
`ifdef PIPE_MUL_HIGH_EN
                        midop_q[i] <= midop_q[i-1];
`endif
                    end
                end
                if (flush) begin
                    midv_q <= '0;
                end else if (!stall) begin
                    midv_q[0] <= v1_q;
                    for (int unsigned i = 1; i < NMID; i++) begin
                        midv_q[i] <= midv_q[i-1];
                    end
                end
            end
        end

        assign fin_prod_c = mid_q[NMID-1];
        assign fin_v_c    = midv_q[NMID-1];
`ifdef PIPE_MUL_HIGH_EN
        assign fin_op_c   = midop_q[NMID-1];
`endif
    end else begin : g_nomid
        assign fin_prod_c = prod_c;
        assign fin_v_c    = v1_q;
`ifdef PIPE_MUL_HIGH_EN
        assign fin_op_c   = op1_q;
`endif
    end

    // Half selection: MUL takes the low half, every other op the high half
    always_comb begin
        result_d = fin_prod_c[WIDTH-1:0];
`ifdef PIPE_MUL_HIGH_EN
        if (fin_op_c != 2'b00) begin
            result_d = fin_prod_c[2*WIDTH-1:WIDTH];
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            result    <= '0;
            out_valid <= 1'b0;
        end else begin
            if (!stall) begin
                result <= result_d;
            end
            if (flush) begin
                out_valid <= 1'b0;
            end else if (!stall) begin
                out_valid <= fin_v_c;
            end
        end
    end

endmodule

// File: tb/tb_pipe_mul.sv
// Scoreboard bench for pipe_mul: the driver queues expected results, a negedge monitor checks them.
// Expected values follow whether PIPE_MUL_HIGH_EN is defined for the build.
module tb_pipe_mul;
    localparam int unsigned WIDTH  = 32;
    localparam int unsigned STAGES = 2;
    localparam int unsigned NV     = 12;

    typedef struct packed {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_full;
        logic [31:0] exp_low;
    } vec_t;

    // Hand-computed: exp_full with all ops built, exp_low when only MUL exists
    vec_t vecs [NV] = '{
        '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001},
        '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001},
        '{2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001},
        '{2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001},
        '{2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000},
        '{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 32'h0000_0000},
        '{2'b00, 32'h0000_0007, 32'h0000_0006, 32'h0000_002A, 32'h0000_002A},
        '{2'b11, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000},
        '{2'b10, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA},
        '{2'b10, 32'h0000_0003, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFD},
        '{2'b01, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001},
        '{2'b01, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE}
    };

    logic             clk = 1'b0;
    logic             rst_n;
    logic             stall;
    logic             flush;
    logic             in_valid;
    logic [1:0]       op;
    logic [WIDTH-1:0] opA;
    logic [WIDTH-1:0] opB;
    logic             out_valid;
    logic [WIDTH-1:0] result;

    int               pass_cnt = 0;
    int               chk_cnt  = 0;
    logic [WIDTH-1:0] exp_q [$];
    logic             stall_seen = 1'b0;

    always #5 clk = ~clk;

    pipe_mul #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .stall     (stall),
        .flush     (flush),
        .in_valid  (in_valid),
        .op        (op),
        .opA       (opA),
        .opB       (opB),
        .out_valid (out_valid),
        .result    (result)
    );

    function automatic void check(string name, logic [63:0] act, logic [63:0] req);
        chk_cnt++;
        if (act === req) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    endfunction

    function automatic logic [31:0] exp_of(int idx);
`ifdef PIPE_MUL_HIGH_EN
        return vecs[idx].exp_full;
`else
        return vecs[idx].exp_low;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(int idx, bit keep);
        in_valid = 1'b1;
        op       = vecs[idx].op;
        opA      = vecs[idx].a;
        opB      = vecs[idx].b;
        if (keep) exp_q.push_back(exp_of(idx));
    endtask

    // Edges from driving an op until out_valid first rises
    task automatic wait_out(string name, int unsigned want);
        int unsigned lat  = 0;
        bit          seen = 1'b0;
        while (!seen && lat < want + 4) begin
            tick();
            in_valid = 1'b0;
            lat++;
            seen = out_valid;
        end
        check(name, seen ? 64'(lat) : 64'd0, 64'(want));
    endtask

    task automatic count_valid(int unsigned n, output int unsigned cnt);
        cnt = 0;
        for (int unsigned i = 0; i < n; i++) begin
            tick();
            if (out_valid === 1'b1) cnt++;
        end
    endtask

    // Monitor: a non-stalled edge with out_valid high presents a new result
    always @(posedge clk) stall_seen <= stall;

    always @(negedge clk) begin
        if (out_valid === 1'b1 && !stall_seen) begin
            if (exp_q.size() == 0) check("unexpected_out_valid", 64'(out_valid), 64'd0);
            else check("result", 64'(result), 64'(exp_q.pop_front()));
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int unsigned cnt;
        int          first;
        int          last;
        int          hi_cnt;

        rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
        in_valid = 1'b0; op = 2'b00; opA = '0; opB = '0;
        tick();
        tick();
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_result", 64'(result), 64'd0);

        // First op after reset release
        rst_n = 1'b1;
        drive(6, 1'b1);
        wait_out("latency_after_reset", STAGES);
        tick();

        // Back-to-back issue of the whole table
        first = -1; last = -1; hi_cnt = 0;
        for (int i = 0; i < int'(NV) + int'(STAGES) + 2; i++) begin
            if (i < int'(NV)) drive(i, 1'b1);
            else in_valid = 1'b0;
            tick();
            if (out_valid === 1'b1) begin
                hi_cnt++;
                if (first < 0) first = i;
                last = i;
            end
        end
        check("b2b_count", 64'(hi_cnt), 64'(NV));
        check("b2b_span", 64'(last - first + 1), 64'(NV));

        // 7*6 captured, then two stalled edges
        drive(6, 1'b1);
        tick();
        in_valid = 1'b0;
        stall = 1'b1;
        tick();
        check("stall_e2_valid", 64'(out_valid), 64'd0);
        tick();
        check("stall_e3_valid", 64'(out_valid), 64'd0);
        stall = 1'b0;
        tick();
        check("stall_e4_valid", 64'(out_valid), 64'd1);
        check("stall_e4_result", 64'(result), 64'd42);
        stall = 1'b1;
        tick();
        tick();
        check("stall_hold_valid", 64'(out_valid), 64'd1);
        check("stall_hold_result", 64'(result), 64'd42);
        stall = 1'b0;
        tick();
        check("after_stall_valid", 64'(out_valid), 64'd0);

        // Stall mid-stream with the next op held on the inputs
        drive(8, 1'b1);
        tick();
        drive(9, 1'b1);
        stall = 1'b1;
        tick();
        tick();
        stall = 1'b0;
        tick();
        drive(10, 1'b1);
        tick();
        in_valid = 1'b0;
        count_valid(STAGES + 2, cnt);

        // Flush held while the second and third ops are presented: none survive
        drive(0, 1'b0);
        tick();
        drive(1, 1'b0);
        flush = 1'b1;
        tick();
        check("flush_kill_valid", 64'(out_valid), 64'd0);
        drive(2, 1'b0);
        tick();
        check("flush_discard_valid", 64'(out_valid), 64'd0);
        flush = 1'b0;
        in_valid = 1'b0;
        count_valid(STAGES + 2, cnt);
        check("flush_no_output", 64'(cnt), 64'd0);

        // Flush while stalled still kills the in-flight op
        drive(3, 1'b0);
        tick();
        in_valid = 1'b0;
        stall = 1'b1;
        flush = 1'b1;
        tick();
        check("flush_stall_valid", 64'(out_valid), 64'd0);
        stall = 1'b0;
        flush = 1'b0;
        count_valid(STAGES + 2, cnt);
        check("flush_stall_no_output", 64'(cnt), 64'd0);

        // A completed result held by stall is cleared by flush
        drive(4, 1'b1);
        wait_out("latency_mulh", STAGES);
        stall = 1'b1;
        tick();
        check("held_before_flush", 64'(out_valid), 64'd1);
        flush = 1'b1;
        tick();
        check("held_flushed", 64'(out_valid), 64'd0);
        stall = 1'b0;
        flush = 1'b0;
        tick();

        // Reset with ops in flight, then a fresh op
        drive(5, 1'b0);
        tick();
        drive(7, 1'b0);
        rst_n = 1'b0;
        tick();
        check("midreset_out_valid", 64'(out_valid), 64'd0);
        check("midreset_result", 64'(result), 64'd0);
        rst_n = 1'b1;
        drive(11, 1'b1);
        wait_out("latency_after_midreset", STAGES);
        count_valid(3, cnt);

        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
